mem_wb_stage: RTL and testbench

//  MEM stage plus MEM/WB pipeline register of the 5-stage pipeline; consumes the EX/MEM latch outputs.

---
 rtl/mem_wb_stage_if.sv | 30 +++
 rtl/mem_wb_stage.sv | 112 +++++++++++
 tb/tb_mem_wb_stage.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// EX/MEM-to-MEM/WB bundle: the EX/MEM latch fields plus stall in, the registered write-back fields out.
interface mem_wb_stage_if #(
    parameter int DATA_W = 32
);
    logic              stall;
    logic [DATA_W-1:0] alu_result_in;
    logic [DATA_W-1:0] write_data_in;
    logic [4:0]        write_reg_in;
    logic              mem_read_in;
    logic              mem_write_in;
    logic              mem_to_reg_in;
    logic              reg_write_in;
    logic [DATA_W-1:0] wb_data_out;
    logic [4:0]        wb_reg_out;
    logic              wb_regwrite_out;
    logic              mem_fault_out;
    logic              init_busy_out;

    modport master (
        output stall, alu_result_in, write_data_in, write_reg_in,
               mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in,
        input  wb_data_out, wb_reg_out, wb_regwrite_out, mem_fault_out, init_busy_out
    );

    modport slave (
        input  stall, alu_result_in, write_data_in, write_reg_in,
               mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in,
        output wb_data_out, wb_reg_out, wb_regwrite_out, mem_fault_out, init_busy_out
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage + MEM/WB register: word RAM with zero-fill after reset, fault detection, write-back select.
// Latency 1 cycle to the WB outputs; stall holds the MEM/WB register and blocks RAM writes.
module mem_wb_stage #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_wb_stage_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0]   ram_q [DEPTH];

    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [4:0]          wb_reg_q, wb_reg_d;
    logic                wb_regwrite_q, wb_regwrite_d;
    logic                mem_fault_q, mem_fault_d;

    logic [ADDR_W-1:0]   word_idx;
    logic                access;
    logic                fault;
    logic                store_ok;
    logic [DATA_W-1:0]   load_data;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [DATA_W-1:0]   ram_wdata;

    assign word_idx = bus.alu_result_in[ADDR_W+1:2];
    assign access   = bus.mem_read_in | bus.mem_write_in;
    assign fault    = access && ((bus.alu_result_in[1:0] != 2'b00) ||
                                 (bus.alu_result_in[DATA_W-1:ADDR_W+2] != '0));

    always_comb begin
        state_d       = state_q;
        clr_ptr_d     = clr_ptr_q;
        wb_data_d     = wb_data_q;
        wb_reg_d      = wb_reg_q;
        wb_regwrite_d = wb_regwrite_q;
        mem_fault_d   = mem_fault_q;
        store_ok      = 1'b0;
        load_data     = '0;
        ram_we        = 1'b0;
        ram_waddr     = clr_ptr_q;
        ram_wdata     = '0;

        case (state_q)
            ST_INIT: begin
                // Zero one word per cycle; the pipeline sees bubbles until the fill completes.
                ram_we        = 1'b1;
                clr_ptr_d     = clr_ptr_q + ADDR_W'(1);
                wb_data_d     = '0;
                wb_reg_d      = '0;
                wb_regwrite_d = 1'b0;
                mem_fault_d   = 1'b0;
                if (&clr_ptr_q) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                store_ok  = bus.mem_write_in && !fault && !bus.stall;
                ram_we    = store_ok;
                ram_waddr = word_idx;
                ram_wdata = bus.write_data_in;
                // Write-first: a same-cycle store to the loaded word forwards its data.
                if (!fault) begin
                    load_data = store_ok ? bus.write_data_in : ram_q[word_idx];
                end
                if (!bus.stall) begin
                    wb_data_d     = bus.mem_to_reg_in ? load_data : bus.alu_result_in;
                    wb_reg_d      = bus.write_reg_in;
                    wb_regwrite_d = bus.reg_write_in && !(fault && bus.mem_read_in);
                    mem_fault_d   = fault;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_INIT;
            clr_ptr_q     <= '0;
            wb_data_q     <= '0;
            wb_reg_q      <= '0;
            wb_regwrite_q <= 1'b0;
            mem_fault_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_ptr_q     <= clr_ptr_d;
            wb_data_q     <= wb_data_d;
            wb_reg_q      <= wb_reg_d;
            wb_regwrite_q <= wb_regwrite_d;
            mem_fault_q   <= mem_fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            ram_q[ram_waddr] <= ram_wdata;
        end
    end

    assign bus.wb_data_out     = wb_data_q;
    assign bus.wb_reg_out      = wb_reg_q;
    assign bus.wb_regwrite_out = wb_regwrite_q;
    assign bus.mem_fault_out   = mem_fault_q;
    assign bus.init_busy_out   = (state_q == ST_INIT);
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: zero-fill timing, load/store, write-first, faults, stall, reset mid-fill.
module tb_mem_wb_stage;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_wb_stage_if #(.DATA_W(32)) bus ();

    mem_wb_stage #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic m2r, input logic rw,
                          input logic [31:0] addr, input logic [31:0] wdat, input logic [4:0] wreg);
        bus.mem_read_in   = rd;
        bus.mem_write_in  = wr;
        bus.mem_to_reg_in = m2r;
        bus.reg_write_in  = rw;
        bus.alu_result_in = addr;
        bus.write_data_in = wdat;
        bus.write_reg_in  = wreg;
    endtask

    task automatic idle;
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    // Counts cycles until init_busy_out drops, bounded so a stuck fill still reaches the summary.
    task automatic wait_init(input string tag);
        int cyc = 0;
        while (bus.init_busy_out === 1'b1 && cyc < 200) begin
            tick;
            cyc++;
        end
        check(tag, 32'(cyc), 32'd64);
    endtask

    task automatic load_expect(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        set_op(1'b1, 1'b0, 1'b1, 1'b1, addr, 32'h0, 5'd1);
        tick;
        check(tag, bus.wb_data_out, exp);
    endtask

    initial begin
        bus.stall = 1'b0;
        idle;
        reset = 1'b1;
        tick;
        check("rst_busy",     32'(bus.init_busy_out),   32'd1);
        check("rst_wb_data",  bus.wb_data_out,          32'h0);
        check("rst_wb_reg",   32'(bus.wb_reg_out),      32'h0);
        check("rst_regwrite", 32'(bus.wb_regwrite_out), 32'h0);
        check("rst_fault",    32'(bus.mem_fault_out),   32'h0);
        reset = 1'b0;
        wait_init("init_len");

        // Freshly filled RAM reads zero
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h4, 32'h0, 5'd3);
        tick;
        check("zero_ld_data",  bus.wb_data_out,          32'h0);
        check("zero_ld_rw",    32'(bus.wb_regwrite_out), 32'd1);
        check("zero_ld_reg",   32'(bus.wb_reg_out),      32'd3);
        load_expect("zero_ld_3c", 32'h3C, 32'h0);

        // Store then load
        set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0);
        tick;
        check("st_alu_pass", bus.wb_data_out,        32'h10);
        check("st_fault",    32'(bus.mem_fault_out), 32'h0);
        load_expect("ld_10", 32'h10, 32'hDEADBEEF);

        // Same-cycle load+store is write-first
        set_op(1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 32'h12345678, 5'd5);
        tick;
        check("wr_first", bus.wb_data_out, 32'h12345678);
        load_expect("ld_20", 32'h20, 32'h12345678);

        // Misaligned store and out-of-range load
        set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h13, 32'hFFFFFFFF, 5'd0);
        tick;
        check("mis_st_fault", 32'(bus.mem_fault_out), 32'd1);
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 32'h0, 5'd6);
        tick;
        check("oor_ld_fault", 32'(bus.mem_fault_out),   32'd1);
        check("oor_ld_rw",    32'(bus.wb_regwrite_out), 32'd0);
        check("oor_ld_data",  bus.wb_data_out,          32'h0);
        check("oor_ld_reg",   32'(bus.wb_reg_out),      32'd6);
        idle;
        tick;
        check("fault_pulse", 32'(bus.mem_fault_out), 32'd0);
        load_expect("ld_10_intact", 32'h10, 32'hDEADBEEF);

        // Stalled store: nothing written, outputs held
        bus.stall = 1'b1;
        set_op(1'b0, 1'b1, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D, 5'd7);
        tick;
        check("stall_data", bus.wb_data_out,          32'hDEADBEEF);
        check("stall_reg",  32'(bus.wb_reg_out),      32'd1);
        check("stall_rw",   32'(bus.wb_regwrite_out), 32'd1);
        bus.stall = 1'b0;
        load_expect("stall_no_wr", 32'h8, 32'h0);
        set_op(1'b0, 1'b1, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D, 5'd7);
        tick;
        check("st8_alu", bus.wb_data_out,     32'h8);
        check("st8_reg", 32'(bus.wb_reg_out), 32'd7);
        load_expect("ld_8", 32'h8, 32'hCAFEF00D);

        // Fault flag holds under stall
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h401, 32'h0, 5'd2);
        tick;
        check("flt2", 32'(bus.mem_fault_out), 32'd1);
        bus.stall = 1'b1;
        idle;
        tick;
        check("flt_stall_hold", 32'(bus.mem_fault_out), 32'd1);
        bus.stall = 1'b0;

        // Reset, abort the fill at cycle 30, reset again; inputs ignored during fill
        reset = 1'b1;
        tick;
        reset = 1'b0;
        set_op(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h77, 5'd9);
        repeat (30) tick;
        check("fill30_busy", 32'(bus.init_busy_out),   32'd1);
        check("fill30_data", bus.wb_data_out,          32'h0);
        check("fill30_rw",   32'(bus.wb_regwrite_out), 32'd0);
        check("fill30_reg",  32'(bus.wb_reg_out),      32'd0);
        reset = 1'b1;
        tick;
        check("rst2_busy", 32'(bus.init_busy_out), 32'd1);
        reset = 1'b0;
        wait_init("refill_len");
        idle;
        load_expect("clr_10", 32'h10, 32'h0);
        load_expect("clr_20", 32'h20, 32'h0);
        load_expect("clr_08", 32'h8,  32'h0);
        load_expect("clr_40", 32'h40, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
